// File: rtl/gpio_ahb_irq.sv
// rtl/gpio_ahb_irq.sv - AHB-Lite GPIO slave with atomic output ops, byte lanes and per-pin interrupts
// Optional input debounce filter enabled by GPIO_AHB_IRQ_DEBOUNCE_EN
module gpio_ahb_irq #(
    parameter int                gpio_w  = 8,
    parameter logic [gpio_w-1:0] gpo_rst = '0
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic [5:0]        haddr,
    output logic [31:0]       hrdata,
    input  logic [31:0]       hwdata,
    input  logic              hsel,
    input  logic              hwrite,
    input  logic [1:0]        htrans,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    output logic [1:0]        hresp,
    output logic              hready,
    output logic              irq,
    input  logic [gpio_w-1:0] gpi,
    output logic [gpio_w-1:0] gpo,
    output logic [gpio_w-1:0] gpd
);
    localparam logic [3:0] reg_gpi   = 4'h0;
    localparam logic [3:0] reg_gpo   = 4'h1;
    localparam logic [3:0] reg_gpd   = 4'h2;
    localparam logic [3:0] reg_set   = 4'h3;
    localparam logic [3:0] reg_clr   = 4'h4;
    localparam logic [3:0] reg_tgl   = 4'h5;
    localparam logic [3:0] reg_ie    = 4'h6;
    localparam logic [3:0] reg_itype = 4'h7;
    localparam logic [3:0] reg_ipol  = 4'h8;
    localparam logic [3:0] reg_istat = 4'h9;
    localparam logic [3:0] reg_dbdiv = 4'hA;
`ifdef GPIO_AHB_IRQ_DEBOUNCE_EN
    localparam logic [3:0] last_reg  = reg_dbdiv;
`else
    localparam logic [3:0] last_reg  = reg_istat;
`endif

    logic              accept, legal, wr, err1, err2;
    logic              dp_valid, dp_write;
    logic [5:0]        dp_addr;
    logic [3:0]        strb, dp_strb;
    logic [31:0]       mask, wdm, rd_val;
    logic [gpio_w-1:0] s1, s2, s3, cur, prev, ev, w1c;
    logic [gpio_w-1:0] gpo_q, gpd_q, ie_q, itype_q, ipol_q, istat_q;

    assign accept = hsel & htrans[1] & hready;
    assign legal  = (hsize <= 3'd2) && (haddr[5:2] <= last_reg);

    always_comb begin
        strb = 4'b1111;
        case (hsize)
            3'd0:    strb = 4'b0001 << haddr[1:0];
            3'd1:    strb = haddr[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
    end

    // err1 is the stalled first ERROR cycle, err2 the completing one
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
            dp_strb  <= '0;
            err1     <= 1'b0;
            err2     <= 1'b0;
        end else begin
            dp_valid <= accept & legal;
            err1     <= accept & ~legal;
            err2     <= err1;
            if (accept) begin
                dp_write <= hwrite;
                dp_addr  <= haddr;
                dp_strb  <= strb;
            end
        end
    end

    assign hready = ~err1;
    assign hresp  = {1'b0, err1 | err2};
    assign mask   = {{8{dp_strb[3]}}, {8{dp_strb[2]}}, {8{dp_strb[1]}}, {8{dp_strb[0]}}};
    assign wdm    = hwdata & mask;
    assign wr     = dp_valid & dp_write;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= gpi;
            s2 <= s1;
            s3 <= s2;
        end
    end

`ifdef GPIO_AHB_IRQ_DEBOUNCE_EN
    logic [15:0]       dbdiv_q, pre_cnt;
    logic              tick;
    logic [gpio_w-1:0] cand, filt, filt_d;
    logic [1:0]        stab [gpio_w];
    logic              unused_ok;

    assign tick = (pre_cnt == dbdiv_q);

    // A pin's filtered value follows its candidate only after three stable ticks
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dbdiv_q <= '0;
            pre_cnt <= '0;
            cand    <= '0;
            filt    <= '0;
            filt_d  <= '0;
            for (int i = 0; i < gpio_w; i++) stab[i] <= 2'd0;
        end else begin
            if (wr && dp_addr[5:2] == reg_dbdiv) begin
                dbdiv_q <= (dbdiv_q & ~mask[15:0]) | wdm[15:0];
                pre_cnt <= '0;
            end else begin
                pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
            end
            filt_d <= filt;
            for (int i = 0; i < gpio_w; i++) begin
                if (s2[i] != cand[i]) begin
                    cand[i] <= s2[i];
                    stab[i] <= 2'd0;
                end else if (tick && stab[i] != 2'd3) begin
                    stab[i] <= stab[i] + 2'd1;
                end
                if (stab[i] == 2'd3) filt[i] <= cand[i];
            end
        end
    end

    assign cur       = filt;
    assign prev      = filt_d;
    assign unused_ok = ^{hburst, hwdata, mask, wdm, dp_addr, s3};
`else
    logic unused_ok;

    assign cur       = s2;
    assign prev      = s3;
    assign unused_ok = ^{hburst, hwdata, mask, wdm, dp_addr};
`endif

    assign ev  = (itype_q & ((ipol_q & cur & ~prev) | (~ipol_q & ~cur & prev)))
               | (~itype_q & ~(cur ^ ipol_q));
    assign w1c = (wr && dp_addr[5:2] == reg_istat) ? wdm[gpio_w-1:0] : {gpio_w{1'b0}};

    // OR-ing ev after the clear lets a simultaneous event win over W1C
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            gpo_q   <= gpo_rst;
            gpd_q   <= '0;
            ie_q    <= '0;
            itype_q <= '0;
            ipol_q  <= '0;
            istat_q <= '0;
        end else begin
            istat_q <= (istat_q & ~w1c) | ev;
            if (wr) begin
                case (dp_addr[5:2])
                    reg_gpo:   gpo_q   <= (gpo_q & ~mask[gpio_w-1:0]) | wdm[gpio_w-1:0];
                    reg_gpd:   gpd_q   <= (gpd_q & ~mask[gpio_w-1:0]) | wdm[gpio_w-1:0];
                    reg_set:   gpo_q   <= gpo_q | wdm[gpio_w-1:0];
                    reg_clr:   gpo_q   <= gpo_q & ~wdm[gpio_w-1:0];
                    reg_tgl:   gpo_q   <= gpo_q ^ wdm[gpio_w-1:0];
                    reg_ie:    ie_q    <= (ie_q & ~mask[gpio_w-1:0]) | wdm[gpio_w-1:0];
                    reg_itype: itype_q <= (itype_q & ~mask[gpio_w-1:0]) | wdm[gpio_w-1:0];
                    reg_ipol:  ipol_q  <= (ipol_q & ~mask[gpio_w-1:0]) | wdm[gpio_w-1:0];
                    default:   ;
                endcase
            end
        end
    end

    always_comb begin
        rd_val = 32'd0;
        case (dp_addr[5:2])
            reg_gpi:   rd_val = 32'(cur);
            reg_gpo:   rd_val = 32'(gpo_q);
            reg_gpd:   rd_val = 32'(gpd_q);
            reg_ie:    rd_val = 32'(ie_q);
            reg_itype: rd_val = 32'(itype_q);
            reg_ipol:  rd_val = 32'(ipol_q);
            reg_istat: rd_val = 32'(istat_q);
`ifdef GPIO_AHB_IRQ_DEBOUNCE_EN
            reg_dbdiv: rd_val = {16'd0, dbdiv_q};
`endif
            default:   rd_val = 32'd0;
        endcase
    end

    assign hrdata = (dp_valid & ~dp_write) ? rd_val : 32'd0;
    assign irq    = |(istat_q & ie_q);
    assign gpo    = gpo_q;
    assign gpd    = gpd_q;
endmodule

// File: doc/gpio_ahb_irq.md
Name: gpio_ahb_irq

Overview:
AHB-Lite GPIO slave with up to 32 pins. Extends the plain GPIO peripheral with:
- 2-flop input synchroniser.
- Atomic SET/CLR/TGL output registers.
- Byte-lane writes.
- Per-pin edge/level interrupts with W1C sticky status.
- Two-cycle ERROR response for illegal accesses.
Sits on the AHB peripheral fabric beside the other hclk-domain slaves.

Parameters:
gpio_w, 8, pin count, legal 1..32; unused upper register bits read 0 and ignore writes.
gpo_rst, 0, reset value of GPO (gpio_w bits).

Ports:
hclk  in  1  AHB clock
hresetn  in  1  asynchronous active-low reset
haddr  in  6  byte address within slave window
hrdata  out  32  read data, valid in read data phase
hwdata  in  32  write data, sampled at end of write data phase
hsel  in  1  slave select
hwrite  in  1  1 = write
htrans  in  2  transfer type; htrans[1]=1 (NONSEQ/SEQ) is a valid transfer
hsize  in  3  0 = byte, 1 = half, 2 = word; >2 is illegal
hburst  in  3  ignored
hresp  out  2  00 = OKAY, 01 = ERROR
hready  out  1  transfer done / slave ready
irq  out  1  interrupt request
gpi  in  gpio_w  asynchronous pin inputs
gpo  out  gpio_w  output values
gpd  out  gpio_w  direction, 1 = output

Behaviour:
Clocking and reset:
- Single clock hclk.
- hresetn is asynchronous, active-low.
- Reset values: hready=1, hresp=00, hrdata=0, irq=0, gpo=gpo_rst, gpd=0; all other registers 0.

Register map (word offsets):
- 0x00 GPI, RO, synchronised (or filtered) input.
- 0x04 GPO, RW.
- 0x08 GPD, RW.
- 0x0C SET, WO: GPO |= wd.
- 0x10 CLR, WO: GPO &= ~wd.
- 0x14 TGL, WO: GPO ^= wd.
- 0x18 IE, RW.
- 0x1C ITYPE, RW: 1 = edge, 0 = level.
- 0x20 IPOL, RW: 1 = rising/high, 0 = falling/low.
- 0x24 ISTAT, RW1C.
- 0x28..0x3C unmapped (0x28 becomes DBDIV when the optional feature is compiled in).
- WO registers read 0.

AHB pipeline:
- Address phase is accepted when hsel & htrans[1] & hready.
- On acceptance, register addr, hwrite and hsize.
- Zero wait states on OKAY.
- Write commits at the clock edge ending the data phase.
- Read: hrdata is driven combinationally from the registered address during the data phase; 0 otherwise.
- Back-to-back write then read of the same register returns the new value.
- Byte lanes:
  - hsize=0: strobe bit haddr[1:0].
  - hsize=1: lanes {haddr[1],0} and {haddr[1],1}.
  - hsize=2: all four lanes.
  - Strobes apply to RW, SET/CLR/TGL and W1C writes.

Error response:
- Triggered by an unmapped address, or hsize>2, at acceptance.
- Data-phase cycle 1: hready=0, hresp=01.
- Cycle 2: hready=1, hresp=01.
- Then return to OKAY.
- Write is discarded; read returns 0.
- No new address phase is accepted while hready=0.

Input path:
- gpi passes through s1, then s2, then s3 (previous value).
- GPI reads s2.
- Edge event (per pin): ITYPE=1 and (s2 & ~s3 when IPOL=1, else ~s2 & s3).
- Level event (per pin): ITYPE=0 and s2 == IPOL.
- ISTAT bit sets on an event, independent of IE.
- W1C of a bit in the same cycle as an event on that bit: set wins.
- Level source still active after W1C: bit re-sets next cycle.
- irq = |(ISTAT & IE), combinational from registers.
- Latency: gpi edge before hclk edge 1 → ISTAT set at edge 3 → irq high right after edge 3.
- Changing ITYPE/IPOL does not clear ISTAT.

Optional Feature:
Macro: GPIO_AHB_IRQ_DEBOUNCE_EN.

When defined:
- Register 0x28 DBDIV, RW, 16 bits, reset 0.
- Prescaler counts 0..DBDIV and emits a tick on wrap.
- Per pin: a 2-bit stable counter increments on ticks while s2 equals the candidate value, and restarts on change.
- Filtered bit takes the candidate once the counter reaches 3.
- GPI and the event logic use the filtered value f in place of s2; the previous filtered value replaces s3.
- Writing DBDIV resets the prescaler.

When undefined:
- 0x28 is unmapped (ERROR response).
- No filter logic is present.

Test Plan:
- Reset mid-operation: assert hresetn during an ERROR wait cycle → hready=1, hresp=00, gpo=gpo_rst, irq=0 immediately.
- Atomic ops: write GPO=0x0F; SET 0x30; CLR 0x01; TGL 0x81 → GPO reads 0x0F, 0x3F, 0x3E, 0xBF; gpo pin matches one cycle after each data phase.
- Byte lanes: write 0xAA55_1234 to GPD with hsize=0 at haddr=0x09 (gpio_w=32) → GPD reads 0x0000_1200; hsize=1 at haddr=0x0A → GPD=0xAA55_1200.
- Edge irq: IE=0x01, ITYPE=0x01, IPOL=0x01; gpi[0] 0→1 → ISTAT=0x01 and irq=1 after 3 edges; W1C 0x01 → irq=0; W1C in same cycle as a new rising edge → ISTAT stays 1.
- Level irq: ITYPE=0, IPOL=0, gpi[2] held 0, IE=0x04 → W1C 0x04 re-sets next cycle, irq stays 1; set gpi[2]=1 then W1C → irq=0.
- Error: read 0x30, then write hsize=3 to 0x04 → each gives hready 0 then 1 with hresp=01; GPO unchanged; next OKAY read of 0x04 has zero wait states.
